// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 9-bit instructions from a synchronous ROM and issues them to the control unit
// Ports:
//   clk      rising-edge clock
//   Resetn   asynchronous active-low reset
//   Start    begin execution at address 0 (accepted only when idle and Halt is low)
//   Halt     stop at the next instruction boundary
//   MemAddr  ROM address, combinational from state and PC
//   MemData  ROM read data, valid one cycle after MemAddr
//   IR       latched instruction word
//   DIN      latched immediate word for mvi
//   Run      one-cycle issue pulse
//   Done     completion strobe from the control unit
//   PC       address of the current instruction
//   Busy     high whenever the sequencer is not idle
//   Fault    sticky Done-timeout flag
module instr_sequencer #(
   parameter int ADDR_W       = 5,
   parameter int DONE_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              Resetn,
   input  logic              Start,
   input  logic              Halt,
   output logic [ADDR_W-1:0] MemAddr,
   input  logic [8:0]        MemData,
   output logic [8:0]        IR,
   output logic [8:0]        DIN,
   output logic              Run,
   input  logic              Done,
   output logic [ADDR_W-1:0] PC,
   output logic              Busy,
   output logic              Fault
);
   localparam int CW = $clog2(DONE_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, IMM_FETCH, IMM_LATCH, ISSUE, WAIT_DONE, ADVANCE} state_t;
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_nxt, pc_inc;
   logic [8:0]        ir_nxt, din_nxt;
   logic              fault_nxt, halt_pending, hp_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   assign pc_inc  = PC + ADDR_W'(1);
   assign MemAddr = (state == IMM_FETCH || state == IMM_LATCH) ? pc_inc : PC;
   assign Run     = state == ISSUE;
   assign Busy    = state != IDLE;
   always_comb begin
      state_nxt = state;
      pc_nxt    = PC;
      ir_nxt    = IR;
      din_nxt   = DIN;
      fault_nxt = Fault;
      cnt_nxt   = cnt;
      case (state)
         IDLE:      if (Start && !Halt) begin
                       state_nxt = FETCH;
                       pc_nxt    = '0;
                       fault_nxt = 1'b0;
                    end
         FETCH:     state_nxt = LATCH;
         // Opcodes 4-7 (MSB set) are reserved and skipped without a Run pulse
         LATCH:     begin
                       ir_nxt    = MemData;
                       state_nxt = MemData[8:6] == 3'd1 ? IMM_FETCH : MemData[8] ? ADVANCE : ISSUE;
                    end
         IMM_FETCH: state_nxt = IMM_LATCH;
         IMM_LATCH: begin
                       din_nxt   = MemData;
                       state_nxt = ISSUE;
                    end
         ISSUE:     begin
                       cnt_nxt   = '0;
                       state_nxt = WAIT_DONE;
                    end
         // cnt counts Done-less cycles already spent; the last allowed one trips Fault
         WAIT_DONE: if (Done) state_nxt = ADVANCE;
                    else if (cnt == CW'(DONE_TIMEOUT - 1)) begin
                       fault_nxt = 1'b1;
                       state_nxt = IDLE;
                    end else cnt_nxt = cnt + CW'(1);
         ADVANCE:   begin
                       pc_nxt    = PC + (IR[8:6] == 3'd1 ? ADDR_W'(2) : ADDR_W'(1));
                       state_nxt = halt_pending ? IDLE : FETCH;
                    end
         default:   state_nxt = IDLE;
      endcase
      // Pending halt survives until the sequencer returns to IDLE by any route
      hp_nxt = state_nxt != IDLE && (halt_pending || Halt);
   end
   always_ff @(posedge clk or negedge Resetn) begin
      if (!Resetn) begin
         state        <= IDLE;
         PC           <= '0;
         IR           <= '0;
         DIN          <= '0;
         Fault        <= 1'b0;
         halt_pending <= 1'b0;
         cnt          <= '0;
      end else begin
         state        <= state_nxt;
         PC           <= pc_nxt;
         IR           <= ir_nxt;
         DIN          <= din_nxt;
         Fault        <= fault_nxt;
         halt_pending <= hp_nxt;
         cnt          <= cnt_nxt;
      end
   end
endmodule
